// File: rtl/pipeline_fetch.sv
// Instruction fetch stage: in-order imem reads buffered with their PCs in a DEPTH-entry FIFO.
// Define FETCH_PERF_EN to add the 32-bit bubble_count output.
module pipeline_fetch #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    imem_req_valid,
    output logic [ADDR_WIDTH-1:0]   imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_resp_valid,
    input  logic [DATA_WIDTH/2-1:0] imem_resp_data,
    input  logic                    redirect_valid,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc,
    input  logic                    halt,
    input  logic                    decode_ready,
`ifdef FETCH_PERF_EN
    output logic [31:0]             bubble_count,
`endif
    output logic [DATA_WIDTH/2-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]   instruction_pc
);

    localparam int unsigned IW = DATA_WIDTH / 2;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [IW-1:0]         BUBBLE    = IW'(90);
    localparam logic [CW:0]           DEPTH_OCC = (CW+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MSK = ~(ADDR_WIDTH'(3));

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [IW-1:0]         fifo_data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc_q   [DEPTH];

    logic [CW:0]           occ;
    logic                  req_fire;
    logic                  resp_fire;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] redirect_aligned;

    assign occ              = {1'b0, count_q} + {1'b0, inflight_q};
    assign imem_req_valid   = !reset && !redirect_valid && (state_q == ST_RUN) && (occ < DEPTH_OCC);
    assign imem_req_addr    = fetch_pc_q;
    assign req_fire         = imem_req_valid && imem_req_ready;
    // Responses with nothing outstanding (e.g. stale after reset) are ignored.
    assign resp_fire        = imem_resp_valid && (inflight_q != '0);
    assign push             = resp_fire && !redirect_valid && (state_q != ST_DRAIN);
    assign pop              = decode_ready && (count_q != '0) && !redirect_valid;
    assign redirect_aligned = redirect_pc & ALIGN_MSK;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        inflight_d = inflight_q + CW'(req_fire) - CW'(resp_fire);

        if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
        if (push) begin
            tail_d    = tail_q + PW'(1);
            resp_pc_d = resp_pc_q + PC_STEP;
        end
        if (pop) head_d = head_q + PW'(1);

        case (state_q)
            ST_RUN:   if (halt) state_d = ST_HALT;
            ST_DRAIN: if (inflight_d == '0) state_d = ST_RUN;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RUN;
        endcase

        // Redirect wins over halt and drain; request is already suppressed this cycle.
        if (redirect_valid) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = redirect_aligned;
            resp_pc_d  = redirect_aligned;
            state_d    = (inflight_d != '0) ? ST_DRAIN : ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_data_q[tail_q] <= imem_resp_data;
            fifo_pc_q[tail_q]   <= resp_pc_q;
        end
    end

    always_comb begin
        instruction    = BUBBLE;
        instruction_pc = '0;
        if (count_q != '0) begin
            instruction    = fifo_data_q[head_q];
            instruction_pc = fifo_pc_q[head_q];
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] bubble_q, bubble_d;

    always_comb begin
        bubble_d = bubble_q;
        if (decode_ready && (count_q == '0)) bubble_d = bubble_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) bubble_q <= '0;
        else       bubble_q <= bubble_d;
    end

    assign bubble_count = bubble_q;
`endif

endmodule

// File: tb/tb_pipeline_fetch.sv
// Scoreboard bench for pipeline_fetch: directed phases drive fetch/decode/redirect/halt,
// a negedge monitor models instruction memory and checks every word handed to decode.
module tb_pipeline_fetch;

    localparam int unsigned     AW     = 64;
    localparam int unsigned     DW     = 64;
    localparam int unsigned     IW     = 32;
    localparam int unsigned     DEPTH  = 4;
    localparam logic [AW-1:0]   RPC    = 64'h1000;
    localparam logic [IW-1:0]   BUBBLE = 32'd90;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready = 1'b1;
    logic          imem_resp_valid = 1'b0;
    logic [IW-1:0] imem_resp_data = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          halt = 1'b0;
    logic          decode_ready = 1'b1;
    logic [IW-1:0] instruction;
    logic [AW-1:0] instruction_pc;
`ifdef FETCH_PERF_EN
    logic [31:0]   bubble_count;
`endif

    int checks = 0;
    int errors = 0;
    int unsigned mem_lat = 1;
    longint unsigned edge_cnt = 0;

    typedef struct {
        logic [AW-1:0]   addr;
        longint unsigned due;
    } req_t;

    req_t          mem_q[$];
    logic [AW-1:0] sb_q[$];
    logic [AW-1:0] exp_fetch = RPC;

    pipeline_fetch #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halt(halt),
        .decode_ready(decode_ready),
`ifdef FETCH_PERF_EN
        .bubble_count(bubble_count),
`endif
        .instruction(instruction),
        .instruction_pc(instruction_pc)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [IW-1:0] word(input logic [AW-1:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Memory model and scoreboard monitor; sees settled inputs and outputs at negedge.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            mem_q.delete();
            sb_q.delete();
            exp_fetch       = RPC;
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end else begin
            if (decode_ready && !redirect_valid && instruction != BUBBLE) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got pc %h data %h, expected no word", instruction_pc, instruction);
                end else begin
                    logic [AW-1:0] ep;
                    ep = sb_q.pop_front();
                    chk("word_pc", instruction_pc, ep);
                    chk("word_data", 64'(instruction), 64'(word(ep)));
                end
            end
            if (redirect_valid) begin
                sb_q.delete();
                exp_fetch = redirect_pc & ~64'h3;
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_fetch);
                sb_q.push_back(exp_fetch);
                mem_q.push_back('{imem_req_addr, edge_cnt + 1 + mem_lat});
                exp_fetch = exp_fetch + 64'd4;
                chk("occupancy_bound", 64'(sb_q.size() <= DEPTH), 64'd1);
            end
            if (mem_q.size() > 0 && mem_q[0].due <= edge_cnt + 1) begin
                req_t r;
                r = mem_q.pop_front();
                imem_resp_valid = 1'b1;
                imem_resp_data  = word(r.addr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
        end
    end

    // Leaves the bench at the start of cycle 1 (first cycle with reset low).
    task automatic do_reset(input int unsigned lat, input logic dr);
        reset          = 1'b1;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        mem_lat        = lat;
        decode_ready   = dr;
        next_cycle();
        next_cycle();
        at_neg();
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_instruction", 64'(instruction), 64'(BUBBLE));
        chk("rst_instruction_pc", instruction_pc, 64'd0);
`ifdef FETCH_PERF_EN
        chk("rst_bubble_count", 64'(bubble_count), 64'd0);
`endif
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        // Straight-line fetch, 1-cycle memory, decode always ready.
        do_reset(1, 1'b1);
        at_neg();
        chk("first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("first_req_addr", imem_req_addr, 64'h1000);
        next_cycle();
        next_cycle();
        at_neg();
        chk("first_word_pc", instruction_pc, 64'h1000);
        chk("first_word_data", 64'(instruction), 64'h1000_0000_0000 >> 44 == 0 ? 64'hC0DE1000 : 64'hC0DE1000);
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            at_neg();
            chk("steady_no_bubble", 64'(instruction == BUBBLE), 64'd0);
        end
        next_cycle();
        imem_req_ready = 1'b0;
        repeat (3) next_cycle();
        at_neg();
        chk("stall_req_held", 64'(imem_req_valid), 64'd1);
        next_cycle();
        imem_req_ready = 1'b1;
        repeat (6) next_cycle();

        // Backpressure: decode stalled for cycles 1..10.
        do_reset(1, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            at_neg();
            if (c >= 3) chk("bp_head_pc", instruction_pc, 64'h1000);
            if (c >= 5) chk("bp_req_stopped", 64'(imem_req_valid), 64'd0);
            next_cycle();
        end
        decode_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            chk("bp_release_pc", instruction_pc, 64'h1000 + 64'(4 * c));
            next_cycle();
        end
        repeat (4) next_cycle();

        // Redirect with 3 requests in flight, 4-cycle memory.
        do_reset(4, 1'b1);
        repeat (3) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        at_neg();
        chk("redir_req_suppressed", 64'(imem_req_valid), 64'd0);
        next_cycle();
        redirect_valid = 1'b0;
        for (int c = 5; c <= 7; c++) begin
            at_neg();
            chk("drain_no_req", 64'(imem_req_valid), 64'd0);
            chk("drain_bubble", 64'(instruction), 64'(BUBBLE));
            next_cycle();
        end
        at_neg();
        chk("post_drain_req_valid", 64'(imem_req_valid), 64'd1);
        chk("post_drain_req_addr", imem_req_addr, 64'h2000);
        repeat (5) next_cycle();
        at_neg();
        chk("post_drain_word_pc", instruction_pc, 64'h2000);
        repeat (3) next_cycle();

        // Redirect coincident with a response and a pop; misaligned target.
        do_reset(1, 1'b1);
        repeat (9) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2406;
        at_neg();
        chk("coinc_req_suppressed", 64'(imem_req_valid), 64'd0);
        next_cycle();
        redirect_valid = 1'b0;
        at_neg();
        chk("coinc_flushed_instr", 64'(instruction), 64'(BUBBLE));
        chk("coinc_flushed_pc", instruction_pc, 64'd0);
        chk("coinc_req_valid", 64'(imem_req_valid), 64'd1);
        chk("coinc_req_aligned", imem_req_addr, 64'h2404);
        next_cycle();
        at_neg();
        chk("coinc_still_empty", 64'(instruction), 64'(BUBBLE));
        next_cycle();
        at_neg();
        chk("coinc_new_word_pc", instruction_pc, 64'h2404);
        repeat (3) next_cycle();

        // Halt with 2 in flight, 3-cycle memory, then redirect resumes fetch.
        do_reset(3, 1'b1);
        next_cycle();
        halt = 1'b1;
        at_neg();
        chk("halt_cycle_req", 64'(imem_req_valid), 64'd1);
        next_cycle();
        for (int c = 3; c <= 7; c++) begin
            at_neg();
            chk("halt_no_req", 64'(imem_req_valid), 64'd0);
            if (c == 5) chk("halt_word0_pc", instruction_pc, 64'h1000);
            if (c == 6) chk("halt_word1_pc", instruction_pc, 64'h1004);
            if (c == 7) chk("halt_drained", 64'(instruction), 64'(BUBBLE));
            next_cycle();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000;
        at_neg();
        chk("halt_redir_req", 64'(imem_req_valid), 64'd0);
        next_cycle();
        redirect_valid = 1'b0;
        halt           = 1'b0;
        at_neg();
        chk("resume_req_valid", 64'(imem_req_valid), 64'd1);
        chk("resume_req_addr", imem_req_addr, 64'h3000);
        repeat (4) next_cycle();
        at_neg();
        chk("resume_word_pc", instruction_pc, 64'h3000);
        repeat (3) next_cycle();

`ifdef FETCH_PERF_EN
        // Bubble counter with 3-cycle memory: empty cycles 1..4, then words through cycle 8.
        do_reset(3, 1'b1);
        repeat (4) next_cycle();
        at_neg();
        chk("perf_bubbles_first_word", 64'(bubble_count), 64'd4);
        repeat (4) next_cycle();
        at_neg();
        chk("perf_bubbles_steady", 64'(bubble_count), 64'd4);
        repeat (3) next_cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
